// File: rtl/single_macc_ctrl.sv
// Control for a single-multiplier FIR: delay-line writes, tap/coeff sweeps,
// and accumulator dump/valid strobes aligned to the datapath latency.
//
// Ports:
//   Clk_i, Rst_i       clock, synchronous active-high reset
//   DataNd_i           new input sample present this cycle
//   DataWrEn_o         delay-line write enable
//   DataWrAddr_o       delay-line write address
//   ZeroSel_o          write zero instead of sample (init sweep)
//   TapRdAddr_o        delay-line read address
//   CoeffRdAddr_o      coefficient RAM read address
//   RdEn_o             tap read valid
//   First_o, Last_o    first / last tap of a sample, address aligned
//   AccDump_o          latch accumulator into output register
//   DataValid_o        filter output valid
//   Busy_o             state is not IDLE
//   Overrun_o          sticky: a sample arrived while not acceptable
module single_macc_ctrl #(
    parameter int TAPS     = 16,
    parameter int DAW      = 5,
    parameter int PIPE_LAT = 3
) (
    input  logic           Clk_i,
    input  logic           Rst_i,
    input  logic           DataNd_i,
    output logic           DataWrEn_o,
    output logic [DAW-1:0] DataWrAddr_o,
    output logic           ZeroSel_o,
    output logic [DAW-1:0] TapRdAddr_o,
    output logic [3:0]     CoeffRdAddr_o,
    output logic           RdEn_o,
    output logic           First_o,
    output logic           Last_o,
    output logic           AccDump_o,
    output logic           DataValid_o,
    output logic           Busy_o,
    output logic           Overrun_o
);

    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_MACC
    } state_t;

    state_t          state;
    logic [DAW-1:0]  init_addr;
    logic [DAW-1:0]  wp;
    logic [DAW-1:0]  base;
    logic [KW-1:0]   k;
    logic [PIPE_LAT:0] strobe;
    logic            overrun;

    logic in_macc;
    logic k_last;
    logic accept;
    logic drop;

    assign in_macc = (state == S_MACC);
    assign k_last  = (k == K_LAST);

    // A new sample can start in IDLE, or on the final tap cycle so that
    // back-to-back samples keep the multiplier busy with no gap.
    assign accept = DataNd_i && !Rst_i &&
                    ((state == S_IDLE) || (in_macc && k_last));
    assign drop   = DataNd_i && !Rst_i && !accept;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state     <= S_INIT;
            init_addr <= '0;
            wp        <= '0;
            base      <= '0;
            k         <= '0;
            strobe    <= '0;
            overrun   <= 1'b0;
        end else begin
            // Last-tap marker travels alongside the datapath so dump and
            // valid line up with the final accumulate.
            strobe <= {strobe[PIPE_LAT-1:0], in_macc && k_last};

            if (drop) begin
                overrun <= 1'b1;
            end

            unique case (state)
                S_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == '1) begin
                        state <= S_IDLE;
                        wp    <= '0;
                    end
                end
                S_IDLE: begin
                end
                S_MACC: begin
                    k <= k + 1'b1;
                    if (k_last) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase

            // Acceptance overrides the IDLE return on the last tap.
            if (accept) begin
                base  <= wp;
                wp    <= wp + 1'b1;
                k     <= '0;
                state <= S_MACC;
            end
        end
    end

    always_comb begin
        DataWrEn_o    = 1'b0;
        DataWrAddr_o  = '0;
        ZeroSel_o     = 1'b0;
        TapRdAddr_o   = '0;
        CoeffRdAddr_o = '0;
        RdEn_o        = 1'b0;
        First_o       = 1'b0;
        Last_o        = 1'b0;
        AccDump_o     = 1'b0;
        DataValid_o   = 1'b0;
        Busy_o        = 1'b0;
        Overrun_o     = 1'b0;
        if (!Rst_i) begin
            Busy_o       = (state != S_IDLE);
            Overrun_o    = overrun;
            AccDump_o    = strobe[PIPE_LAT-1];
            DataValid_o  = strobe[PIPE_LAT];
            TapRdAddr_o  = base;
            DataWrAddr_o = wp;
            unique case (state)
                S_INIT: begin
                    DataWrEn_o   = 1'b1;
                    ZeroSel_o    = 1'b1;
                    DataWrAddr_o = init_addr;
                end
                S_MACC: begin
                    RdEn_o        = 1'b1;
                    TapRdAddr_o   = base - DAW'(k);
                    CoeffRdAddr_o = 4'(k);
                    First_o       = (k == '0);
                    Last_o        = k_last;
                end
                default: begin
                end
            endcase
            if (accept) begin
                DataWrEn_o   = 1'b1;
                DataWrAddr_o = wp;
                ZeroSel_o    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_single_macc_ctrl.sv
// Bench for single_macc_ctrl: reset/init sweep, a table-driven single
// sample, a scoreboard for streaming, wrap, overrun and mid-MACC reset.
module tb_single_macc_ctrl;

    logic       Clk_i = 1'b0;
    logic       Rst_i = 1'b1;
    logic       DataNd_i = 1'b1;
    logic       DataWrEn_o;
    logic [4:0] DataWrAddr_o;
    logic       ZeroSel_o;
    logic [4:0] TapRdAddr_o;
    logic [3:0] CoeffRdAddr_o;
    logic       RdEn_o;
    logic       First_o;
    logic       Last_o;
    logic       AccDump_o;
    logic       DataValid_o;
    logic       Busy_o;
    logic       Overrun_o;

    single_macc_ctrl #(
        .TAPS(16),
        .DAW(5),
        .PIPE_LAT(3)
    ) dut (
        .Clk_i(Clk_i),
        .Rst_i(Rst_i),
        .DataNd_i(DataNd_i),
        .DataWrEn_o(DataWrEn_o),
        .DataWrAddr_o(DataWrAddr_o),
        .ZeroSel_o(ZeroSel_o),
        .TapRdAddr_o(TapRdAddr_o),
        .CoeffRdAddr_o(CoeffRdAddr_o),
        .RdEn_o(RdEn_o),
        .First_o(First_o),
        .Last_o(Last_o),
        .AccDump_o(AccDump_o),
        .DataValid_o(DataValid_o),
        .Busy_o(Busy_o),
        .Overrun_o(Overrun_o)
    );

    always #5 Clk_i = ~Clk_i;

    int cyc = 0;
    always @(posedge Clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int wpm = 0;
    int nvalid = 0;
    bit sb_on = 1'b0;
    int wq[$];
    int bq[$];
    int dq[$];
    int vq[$];
    int base_cur = 0;
    int j = 0;

    typedef struct {
        logic       nd;
        logic       wren;
        logic [4:0] wraddr;
        logic [4:0] tap;
        logic [3:0] coeff;
        logic       rden;
        logic       first;
        logic       last;
        logic       dump;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got an event, expected none at cycle %0d",
                 nm, cyc);
    endtask

    task automatic step(input logic rst, input logic nd);
        @(posedge Clk_i);
        #1;
        Rst_i = rst;
        DataNd_i = nd;
        @(negedge Clk_i);
    endtask

    task automatic sample();
        @(posedge Clk_i);
        #1;
        Rst_i = 1'b0;
        DataNd_i = 1'b1;
        wq.push_back(wpm);
        bq.push_back(wpm);
        dq.push_back(cyc + 19);
        vq.push_back(cyc + 20);
        wpm = (wpm + 1) % 32;
        @(negedge Clk_i);
    endtask

    function automatic int all_outs();
        return int'({DataWrEn_o, DataWrAddr_o, ZeroSel_o, TapRdAddr_o,
                     CoeffRdAddr_o, RdEn_o, First_o, Last_o, AccDump_o,
                     DataValid_o, Busy_o, Overrun_o});
    endfunction

    always @(negedge Clk_i) begin
        if (sb_on && !Rst_i) begin
            if (DataWrEn_o && !ZeroSel_o) begin
                if (wq.size() == 0) miss("unexp_write");
                else chk("wr_addr", int'(DataWrAddr_o), wq.pop_front());
            end
            if (RdEn_o) begin
                if (First_o) begin
                    if (bq.size() == 0) miss("unexp_first");
                    else base_cur = bq.pop_front();
                    j = 0;
                end
                chk("tap_rd",
                    int'({TapRdAddr_o, CoeffRdAddr_o, Last_o}),
                    ((((base_cur - j) & 31)) << 5) | ((j & 15) << 1)
                    | int'(j == 15));
                j++;
            end
            if (AccDump_o) begin
                if (dq.size() == 0) miss("unexp_dump");
                else chk("dump_cyc", cyc, dq.pop_front());
            end
            if (DataValid_o) begin
                nvalid++;
                if (vq.size() == 0) miss("unexp_valid");
                else chk("valid_cyc", cyc, vq.pop_front());
            end
        end
    end

    initial begin
        for (int r = 0; r < 22; r++) begin
            int k;
            k = r - 1;
            tbl[r].nd     = (r == 0);
            tbl[r].wren   = (r == 0);
            tbl[r].wraddr = 5'd0;
            tbl[r].rden   = (r >= 1) && (r <= 16);
            tbl[r].tap    = tbl[r].rden ? 5'((32 - k) % 32) : 5'd0;
            tbl[r].coeff  = tbl[r].rden ? 4'(k) : 4'd0;
            tbl[r].first  = (r == 1);
            tbl[r].last   = (r == 16);
            tbl[r].dump   = (r == 19);
            tbl[r].valid  = (r == 20);
            tbl[r].busy   = tbl[r].rden;
        end

        // Reset held with DataNd_i high: everything stays low.
        step(1'b1, 1'b1);
        chk("rst_outs", all_outs(), 0);
        step(1'b1, 1'b1);
        chk("rst_outs2", all_outs(), 0);

        // Init sweep zeroes the whole delay line.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0);
            chk("init_addr", int'(DataWrAddr_o), i);
            chk("init_flags",
                int'({DataWrEn_o, ZeroSel_o, RdEn_o, Busy_o, Overrun_o}),
                5'b11010);
        end
        step(1'b0, 1'b0);
        chk("idle_after_init", int'({Busy_o, DataWrEn_o, RdEn_o}), 0);

        // Single sample from IDLE with wp=0.
        for (int r = 0; r < 22; r++) begin
            logic [21:0] act;
            logic [21:0] exp;
            step(1'b0, tbl[r].nd);
            act = {DataWrEn_o, DataWrEn_o ? DataWrAddr_o : 5'd0, ZeroSel_o,
                   TapRdAddr_o, CoeffRdAddr_o, RdEn_o, First_o, Last_o,
                   AccDump_o, DataValid_o, Busy_o};
            exp = {tbl[r].wren, tbl[r].wraddr, 1'b0, tbl[r].tap,
                   tbl[r].coeff, tbl[r].rden, tbl[r].first, tbl[r].last,
                   tbl[r].dump, tbl[r].valid, tbl[r].busy};
            chk($sformatf("single_row%0d", r), int'(act), int'(exp));
        end
        wpm = 1;
        sb_on = 1'b1;

        // Samples every 16 cycles: accepted on the last tap, no gaps.
        for (int n = 0; n < 4; n++) begin
            sample();
            if (n > 0) chk("rden_cont", int'(RdEn_o), 1);
            for (int m = 0; m < 15; m++) begin
                step(1'b0, 1'b0);
                chk("rden_cont", int'(RdEn_o), 1);
            end
        end
        chk("stream_ovr", int'(Overrun_o), 0);
        for (int m = 0; m < 21; m++) step(1'b0, 1'b0);
        chk("stream_nvalid", nvalid, 4);

        // Run until the write pointer wraps; 33rd sample writes 0.
        for (int n = 0; n < 28; n++) begin
            sample();
            if (n == 27) chk("wrap_addr", int'(DataWrAddr_o), 0);
            for (int m = 0; m < 15; m++) step(1'b0, 1'b0);
        end
        for (int m = 0; m < 21; m++) step(1'b0, 1'b0);

        // Sample arriving at k=5 is dropped and flagged.
        sample();
        for (int m = 0; m < 5; m++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("ovr_no_write", int'(DataWrEn_o), 0);
        chk("ovr_k5_first", int'({RdEn_o, CoeffRdAddr_o}), 5'h15);
        step(1'b0, 1'b0);
        chk("ovr_set", int'(Overrun_o), 1);
        for (int m = 0; m < 20; m++) step(1'b0, 1'b0);
        chk("ovr_sticky", int'(Overrun_o), 1);

        // One-cycle reset at k=8 aborts the sample.
        sample();
        for (int m = 0; m < 8; m++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_mid_outs", all_outs(), 0);
        void'(vq.pop_back());
        void'(dq.pop_back());
        wpm = 0;
        step(1'b0, 1'b0);
        chk("rst_init_addr", int'(DataWrAddr_o), 0);
        chk("rst_init_flags",
            int'({DataWrEn_o, ZeroSel_o, RdEn_o, Busy_o, Overrun_o}),
            5'b11010);
        for (int m = 0; m < 34; m++) step(1'b0, 1'b0);
        chk("rst_idle", int'(Busy_o), 0);

        // Recovery: next sample writes address 0 again.
        sample();
        for (int m = 0; m < 22; m++) step(1'b0, 1'b0);
        chk("q_empty", wq.size() + bq.size() + dq.size() + vq.size(), 0);
        chk("total_valid", nvalid, 34);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
